instr_fetch_unit: RTL and testbench

- Fetch stage that generates the fetch PC, issues requests to instruction memory over a request/grant/response-valid bus, and buffers returned instructions in a small prefetch FIFO.
- Its head entry drives InstrF/PCF/PCPlus4F straight into the IF/ID pipeline register.
- Handles branch/jump redirects from EX by discarding in-flight and buffered fetches.
- Honours the hazard-unit stall.

---
 rtl/instr_fetch_unit_pkg.sv | 16 +
 rtl/instr_fetch_unit_fetch_fifo.sv | 72 +++++++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
package instr_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries with flush; reset is synchronous active-low.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1),
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  fetch_entry_t    push_data_i,
    input  logic            pop_i,
    output fetch_entry_t    head_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o,
    output logic            full_o
);

    fetch_entry_t    mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(FIFO_DEPTH - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(FIFO_DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, req/gnt/rvalid instruction-memory bus, prefetch buffer and
// redirect handling. Head of the prefetch buffer drives the IF/ID register directly.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallF,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        FetchValidF
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW:0] DepthW = (CntW + 1)'(FIFO_DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CntW-1:0] outst_q, outst_d;
    logic [CntW-1:0] drop_q, drop_d;

    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_wdata;
    logic [CntW-1:0] fifo_count;
    logic            fifo_empty, fifo_full;
    logic            fifo_push, fifo_pop, fifo_flush;
    logic [CntW:0]   inflight;
    logic            credit_ok, issue, rsp_ok;

    // Buffered plus in-flight fetches may never exceed the buffer size.
    assign inflight   = {1'b0, outst_q} + {1'b0, fifo_count};
    assign credit_ok  = !fifo_full && (inflight < DepthW);
    assign IMEM_ADDR  = fetch_pc_q;
    assign fifo_wdata = '{pc: resp_pc_q, instr: IMEM_RDATA};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        rsp_ok     = IMEM_RVALID && (outst_q != '0);
        IMEM_REQ   = RST && !PCSrcE && credit_ok;
        issue      = IMEM_REQ && IMEM_GNT;
        fifo_pop   = !fifo_empty && !StallF && !PCSrcE;

        if (PCSrcE) begin
            // Everything still in flight after this edge belongs to the old path.
            fetch_pc_d = align_word(PCTargetE);
            resp_pc_d  = align_word(PCTargetE);
            outst_d    = outst_q - CntW'(rsp_ok);
            drop_d     = outst_d;
            fifo_flush = 1'b1;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
            outst_d = outst_q + CntW'(issue) - CntW'(rsp_ok);
            if (rsp_ok) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CntW'(1);
                end else begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .flush_i    (fifo_flush),
        .push_i     (fifo_push),
        .push_data_i(fifo_wdata),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign FetchValidF = !fifo_empty;
    assign InstrF      = fifo_empty ? NOP_INSTR : fifo_head.instr;
    assign PCF         = fifo_empty ? 32'h0 : fifo_head.pc;
    assign PCPlus4F    = fifo_empty ? 32'h0 : fifo_head.pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table for reset/stream/redirect plus hand sequences.
module tb_instr_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT = 1'b0;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = '0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        StallF = 1'b0;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        FetchValidF;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    bit          gnt_en  = 1'b1;
    bit          rsp_en  = 1'b1;
    logic [31:0] mem_q[$];
    int          tb_out  = 0;

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IMEM_REQ   (IMEM_REQ),
        .IMEM_ADDR  (IMEM_ADDR),
        .IMEM_GNT   (IMEM_GNT),
        .IMEM_RVALID(IMEM_RVALID),
        .IMEM_RDATA (IMEM_RDATA),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .StallF     (StallF),
        .InstrF     (InstrF),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .FetchValidF(FetchValidF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          rst;
        bit          stall;
        bit          pcsrc;
        logic [31:0] tgt;
        bit          gnt;
        bit          rsp;
        logic [2:0]  chk;   // [0] REQ, [1] ADDR, [2] head outputs
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit stall, bit pcsrc, logic [31:0] tgt, bit gnt, bit rsp,
                                logic [2:0] chk, bit req, logic [31:0] addr, bit valid,
                                logic [31:0] pc, logic [31:0] instr);
        vec_t v;
        v.rst = rst; v.stall = stall; v.pcsrc = pcsrc; v.tgt = tgt; v.gnt = gnt; v.rsp = rsp;
        v.chk = chk; v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.instr = instr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_head(input string name, input bit valid, input logic [31:0] pc);
        check({name, ".valid"}, 32'(FetchValidF), 32'(valid));
        check({name, ".pcf"}, PCF, valid ? pc : 32'h0);
        check({name, ".instr"}, InstrF, valid ? (pc ^ KEY) : NOP);
        check({name, ".pc4"}, PCPlus4F, valid ? pc + 32'd4 : 32'h0);
    endtask

    // Memory model: grant per gnt_en, answer one cycle after grant (or later if rsp_en=0).
    task automatic settle();
        IMEM_GNT = gnt_en;
        if (RST && rsp_en && mem_q.size() > 0) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = mem_q.pop_front() ^ KEY;
        end else begin
            IMEM_RVALID = 1'b0;
            IMEM_RDATA  = '0;
        end
        assert (!(IMEM_RVALID && tb_out == 0)) else $error("protocol: rvalid with nothing outstanding");
        #1;
    endtask

    task automatic tick();
        bit          g, r, rv;
        logic [31:0] a;
        g  = IMEM_REQ && IMEM_GNT;
        a  = IMEM_ADDR;
        r  = RST;
        rv = IMEM_RVALID;
        @(posedge CLK);
        #1;
        if (!r) begin
            mem_q.delete();
            tb_out = 0;
        end else begin
            if (g) mem_q.push_back(a);
            tb_out = tb_out + int'(g) - int'(rv);
        end
    endtask

    task automatic reset_dut();
        RST = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; gnt_en = 1'b1; rsp_en = 1'b1;
        repeat (2) begin
            settle();
            tick();
        end
        RST = 1'b1;
    endtask

    initial begin
        int          pops;
        logic [31:0] exp_pc;

        // Reset, zero-wait stream, then redirect with two fetches in flight (misaligned target).
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3'b001, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3'b101, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3'b101, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3'b101, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b111, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b111, 1, 32'h4, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b111, 0, 32'h8, 1, 32'h0, 32'hA5A5_A5A5));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b111, 1, 32'h8, 1, 32'h4, 32'hA5A5_A5A1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b111, 1, 32'hC, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b111, 0, 32'h10, 1, 32'h8, 32'hA5A5_A5AD));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b111, 1, 32'h10, 1, 32'hC, 32'hA5A5_A5A9));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 3'b111, 1, 32'h14, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h103, 1, 0, 3'b111, 0, 32'h18, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b111, 0, 32'h100, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b111, 1, 32'h100, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b111, 1, 32'h104, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b111, 0, 32'h108, 1, 32'h100, 32'hA5A5_A4A5));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b111, 1, 32'h108, 1, 32'h104, 32'hA5A5_A4A1));

        foreach (vecs[i]) begin
            RST = vecs[i].rst; StallF = vecs[i].stall; PCSrcE = vecs[i].pcsrc;
            PCTargetE = vecs[i].tgt; gnt_en = vecs[i].gnt; rsp_en = vecs[i].rsp;
            settle();
            if (vecs[i].chk[0]) check($sformatf("v%0d.req", i), 32'(IMEM_REQ), 32'(vecs[i].req));
            if (vecs[i].chk[1]) check($sformatf("v%0d.addr", i), IMEM_ADDR, vecs[i].addr);
            if (vecs[i].chk[2]) begin
                check($sformatf("v%0d.valid", i), 32'(FetchValidF), 32'(vecs[i].valid));
                check($sformatf("v%0d.pcf", i), PCF, vecs[i].pc);
                check($sformatf("v%0d.instr", i), InstrF, vecs[i].valid ? vecs[i].instr : NOP);
                check($sformatf("v%0d.pc4", i), PCPlus4F,
                      vecs[i].valid ? vecs[i].pc + 32'd4 : 32'h0);
            end
            tick();
        end
        PCSrcE = 1'b0;

        // Stall with a full buffer, then release: PCs continue with no gap or duplicate.
        reset_dut();
        StallF = 1'b1;
        repeat (3) begin
            settle();
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("stall%0d.req", i), 32'(IMEM_REQ), 32'd0);
            check_head($sformatf("stall%0d", i), 1'b1, 32'h0);
            tick();
        end
        StallF = 1'b0;
        exp_pc = 32'h0;
        pops   = 0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (FetchValidF) begin
                check_head($sformatf("flow%0d", pops), 1'b1, exp_pc);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            tick();
        end
        check("flow.pops_in_budget", 32'(pops >= 10), 32'd1);

        // Grant withheld at 0x20, then redirect to 0x40 during the wait.
        reset_dut();
        gnt_en = 1'b0;
        PCSrcE = 1'b1; PCTargetE = 32'h20;
        settle();
        tick();
        PCSrcE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("wait%0d.req", i), 32'(IMEM_REQ), 32'd1);
            check($sformatf("wait%0d.addr", i), IMEM_ADDR, 32'h20);
            tick();
        end
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        settle();
        check("redir.req_withdrawn", 32'(IMEM_REQ), 32'd0);
        tick();
        PCSrcE = 1'b0; gnt_en = 1'b1;
        settle();
        check("redir.req", 32'(IMEM_REQ), 32'd1);
        check("redir.addr", IMEM_ADDR, 32'h40);
        check_head("redir.c1", 1'b0, 32'h0);
        tick();
        settle();
        check_head("redir.c2", 1'b0, 32'h0);
        tick();
        settle();
        check_head("redir.c3", 1'b1, 32'h40);
        tick();

        // Reset mid-stream with a buffered entry and one fetch outstanding.
        reset_dut();
        StallF = 1'b1;
        settle();
        tick();
        settle();
        check("mid.req", 32'(IMEM_REQ), 32'd1);
        check("mid.addr", IMEM_ADDR, 32'h4);
        tick();
        rsp_en = 1'b0;
        settle();
        check("mid.credit_full", 32'(IMEM_REQ), 32'd0);
        check_head("mid.buffered", 1'b1, 32'h0);
        tick();
        RST = 1'b0;
        settle();
        check("mid.rst_req", 32'(IMEM_REQ), 32'd0);
        tick();
        settle();
        check("mid.rst_req2", 32'(IMEM_REQ), 32'd0);
        check_head("mid.rst", 1'b0, 32'h0);
        tick();
        RST = 1'b1; StallF = 1'b0; rsp_en = 1'b1;
        settle();
        check("rst.req", 32'(IMEM_REQ), 32'd1);
        check("rst.addr", IMEM_ADDR, 32'h0);
        check_head("rst.c0", 1'b0, 32'h0);
        tick();
        settle();
        check("rst.addr1", IMEM_ADDR, 32'h4);
        check_head("rst.c1", 1'b0, 32'h0);
        tick();
        settle();
        check_head("rst.c2", 1'b1, 32'h0);
        tick();
        settle();
        check_head("rst.c3", 1'b1, 32'h4);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
